lfsr_led_sequencer: RTL and testbench

Parametrised successor to the single-LFSR toggle/demux LED driver: an internal XNOR Fibonacci LFSR of configurable width and taps produces a periodic wrap tick. Each tick flips a blink bit, which is steered onto one of NUM_CH LEDs under one of four selection modes: fixed, rotate, ping-pong or all. It sits at board top level between the switches/clock and the LED bank, and replaces the fixed 22-bit/4-LED version.

---
 rtl/lfsr_led_sequencer.sv | 69 ++++++
 tb/tb_lfsr_led_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/lfsr_led_sequencer.sv
// lfsr_led_sequencer: XNOR LFSR wrap tick blinks one of NUM_CH LEDs in fixed/rotate/ping-pong/all modes
module lfsr_led_sequencer #(
   parameter int LFSR_WIDTH = 22,
   parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS = 22'h300000,
   parameter int NUM_CH = 4,
   localparam int SEL_W = $clog2(NUM_CH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_enable,
   input  logic [1:0]            i_mode,
   input  logic [SEL_W-1:0]      i_sel,
   output logic [NUM_CH-1:0]     o_led,
   output logic                  o_tick,
   output logic [LFSR_WIDTH-1:0] o_lfsr_data
);
   localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);
   localparam logic [SEL_W:0]   NCH  = (SEL_W + 1)'(NUM_CH);
   logic [LFSR_WIDTH-1:0] r_lfsr, lfsr_next;
   logic                  r_tick, r_toggle, r_dir, dir_next;
   logic [SEL_W-1:0]      r_ch, ch_next;
   logic [NUM_CH-1:0]     onehot;
   logic                  fb, sel_ok;
   always_comb begin
      fb        = ~^(r_lfsr & LFSR_TAPS);
      lfsr_next = i_enable ? {r_lfsr[LFSR_WIDTH-2:0], fb} : r_lfsr;
      sel_ok    = {1'b0, i_sel} < NCH;
      onehot    = NUM_CH'(1) << r_ch;
   end
   // a tick already on o_tick still advances the pointer even if i_enable drops at that edge
   always_comb begin
      ch_next  = r_ch;
      dir_next = r_dir;
      if (i_mode == 2'd0) begin
         ch_next = sel_ok ? i_sel : r_ch;
      end else if (r_tick && i_mode == 2'd1) begin
         ch_next = (r_ch == LAST) ? '0 : r_ch + 1'b1;
      end else if (r_tick && i_mode == 2'd2) begin
         if (r_dir && r_ch == LAST) begin
            dir_next = 1'b0;
            ch_next  = r_ch - 1'b1;
         end else if (!r_dir && r_ch == '0) begin
            dir_next = 1'b1;
            ch_next  = SEL_W'(1);
         end else begin
            ch_next  = r_dir ? r_ch + 1'b1 : r_ch - 1'b1;
         end
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lfsr   <= '0;
         r_tick   <= 1'b0;
         r_toggle <= 1'b0;
         r_ch     <= '0;
         r_dir    <= 1'b1;
         o_led    <= '0;
      end else begin
         r_lfsr   <= lfsr_next;
         r_tick   <= i_enable && (lfsr_next == '0);
         r_toggle <= r_toggle ^ r_tick;
         r_ch     <= ch_next;
         r_dir    <= dir_next;
         o_led    <= (i_mode == 2'd3) ? {NUM_CH{r_toggle}} : onehot & {NUM_CH{r_toggle}};
      end
   end
   assign o_tick      = r_tick;
   assign o_lfsr_data = r_lfsr;
endmodule

// File: tb/tb_lfsr_led_sequencer.sv
// tb_lfsr_led_sequencer: random mode/enable/select stimulus against a sequence-index reference model
module tb_lfsr_led_sequencer;
   localparam int W = 3;
   localparam int N = 4;
   localparam int P = 7;
   logic           i_clk = 1'b0;
   logic           i_rst_n = 1'b0;
   logic           i_enable = 1'b0;
   logic [1:0]     i_mode = 2'd0;
   logic [1:0]     i_sel = 2'd0;
   logic [N-1:0]   o_led;
   logic           o_tick;
   logic [W-1:0]   o_lfsr_data;
   int n_cmp = 0;
   int n_err = 0;
   int seq [P] = '{0, 1, 3, 6, 5, 2, 4};
   int m_pos, m_ch;
   bit m_tick, m_tog, m_dir;
   logic [N-1:0] m_led;
   always #5 i_clk = ~i_clk;
   lfsr_led_sequencer #(.LFSR_WIDTH(W), .LFSR_TAPS(3'b110), .NUM_CH(N)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_mode(i_mode),
      .i_sel(i_sel), .o_led(o_led), .o_tick(o_tick), .o_lfsr_data(o_lfsr_data)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask
   task automatic check_all();
      check("lfsr", 32'(o_lfsr_data), 32'(seq[m_pos]));
      check("tick", 32'(o_tick), 32'(m_tick));
      check("led", 32'(o_led), 32'(m_led));
   endtask
   task automatic model_reset();
      m_pos = 0; m_tick = 0; m_tog = 0; m_ch = 0; m_dir = 1; m_led = '0;
   endtask
   // state after the coming rising edge, given the inputs now applied
   task automatic model_step();
      int k, nch;
      bit ntog, ndir;
      nch = m_ch; ntog = m_tog; ndir = m_dir;
      if (m_tick) begin
         ntog = !m_tog;
         if (i_mode == 2'd1) nch = (m_ch + 1) % N;
         if (i_mode == 2'd2) begin
            k    = m_dir ? m_ch : (2*N - 2 - m_ch) % (2*N - 2);
            k    = (k + 1) % (2*N - 2);
            nch  = (k < N) ? k : 2*N - 2 - k;
            ndir = nch > m_ch;
         end
      end
      if (i_mode == 2'd0 && int'(i_sel) < N) nch = int'(i_sel);
      m_led = (i_mode == 2'd3) ? {N{m_tog}} : (N'(1) << m_ch) & {N{m_tog}};
      if (i_enable) m_pos = (m_pos + 1) % P;
      m_tick = i_enable && m_pos == 0;
      m_ch = nch; m_tog = ntog; m_dir = ndir;
   endtask
   // mode < 0 picks a random mode every cycle; en: 0 off, 1 on, 2 random
   task automatic run(input int n, input int mode, input int en);
      repeat (n) begin
         @(negedge i_clk);
         check_all();
         i_enable = (en == 2) ? ($urandom_range(0, 7) != 0) : en[0];
         i_mode   = (mode < 0) ? 2'($urandom_range(0, 3)) : 2'(mode);
         if ($urandom_range(0, 15) == 0) i_sel = 2'($urandom);
         model_step();
      end
   endtask
   task automatic do_reset();
      @(negedge i_clk);
      check_all();
      i_rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge i_clk);
      check_all();
      i_rst_n  = 1'b1;
      i_enable = 1'b1;
      model_step();
   endtask
   initial begin
      model_reset();
      repeat (2) @(negedge i_clk);
      check_all();
      i_rst_n = 1'b1; i_enable = 1'b1; i_mode = 2'd0; i_sel = 2'd2;
      model_step();
      run(16, 0, 1);
      @(negedge i_clk);
      check_all();
      i_sel = 2'd3;
      model_step();
      run(20, 0, 1);
      run(70, 1, 1);
      run(70, 2, 1);
      run(30, 3, 1);
      run(30, 1, 1);
      run(20, 0, 0);
      run(20, 2, 0);
      run(60, 2, 2);
      run(10, 1, 1);
      do_reset();
      run(30, 1, 1);
      repeat (4) begin
         run(int'($urandom_range(3, 40)), -1, 2);
         do_reset();
      end
      run(400, -1, 2);
      run(200, -1, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
